m_seq_32_chk: RTL and testbench
===============================

M_SEQ_32_CHK -- requirements
Module: m_seq_32_chk

Interface
REQ-001 SHALL provide parameter SYNC_LEN, default 32: consecutive error-free bits needed in SYNC before lock.
REQ-002 SHALL provide parameter LOS_WIN, default 64: loss-of-sync window length in valid bits.
REQ-003 SHALL provide parameter LOS_ERR, default 4: errors within one LOS_WIN window that force loss of lock.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 din_valid  input  1  qualifies din; bits with din_valid=0 are ignored entirely.
REQ-007 din  input  1  received serial PRBS bit (newest bit of the 32-bit m-sequence generator, x^32+x^22+x^2+x+1).
REQ-008 clr_cnt  input  1  synchronous clear of err_cnt and bit_cnt.
REQ-009 locked  output  1  high in LOCKED state.
REQ-010 err_pulse  output  1  one-cycle pulse per mismatched bit in SYNC or LOCKED.
REQ-011 err_cnt  output  32  saturating count of errors detected in LOCKED.
REQ-012 bit_cnt  output  32  saturating count of valid bits checked in LOCKED.

Function
REQ-013 SHALL hold a 32-bit reference register sr; expected bit exp = sr[31]^sr[21]^sr[1]^sr[0].
REQ-014 States: HUNT, SYNC, LOCKED; all transitions and updates occur only on cycles with din_valid=1, except reset and clr_cnt.
REQ-015 HUNT: sr <= {sr[30:0], din}; fill counter counts 0..31; after 32nd valid bit -> SYNC, unless the resulting sr is all-zero, in which case remain HUNT with fill counter restarted.
REQ-016 SYNC: sr <= {sr[30:0], exp} (self-running, din not loaded); err = (din != exp); any err -> HUNT with fill counter 0; SYNC_LEN consecutive error-free bits -> LOCKED.
REQ-017 LOCKED: sr <= {sr[30:0], exp}; err increments err_cnt and the window error counter; each valid bit increments bit_cnt and window bit counter.
REQ-018 Window bit counter wraps at LOS_WIN, clearing window error counter on wrap; when window error count reaches LOS_ERR -> HUNT on that same edge.
REQ-019 A single flipped bit SHALL produce exactly one error (reference never reloaded from din outside HUNT).
REQ-020 err_pulse, locked, counters registered: visible the cycle after the edge sampling the din bit.
REQ-021 err_cnt and bit_cnt saturate at 32'hFFFFFFFF, never wrap.
REQ-022 clr_cnt has priority over a same-cycle increment: counters read 0 next cycle; err_pulse still fires.
REQ-023 Counters SHALL hold value on transitions out of LOCKED; only reset or clr_cnt clear them.

Reset
REQ-024 On reset: state HUNT, sr 0, fill/sync/window counters 0, locked 0, err_pulse 0, err_cnt 0, bit_cnt 0.
REQ-025 Reset mid-operation SHALL abandon lock immediately; first post-reset valid bit is fill bit 0.

Configuration
REQ-026 Macro M_SEQ_32_CHK_BITCNT_EN defined: bit_cnt counter implemented per REQ-012/017/021.
REQ-027 M_SEQ_32_CHK_BITCNT_EN undefined: no bit_cnt register; bit_cnt output tied to 32'h0; all other behaviour identical.

Verification
REQ-028 Generator (seed 32'h789ABCDE) feeds din, din_valid=1 every cycle -> locked rises after 64 valid bits (32 HUNT + 32 SYNC), err_cnt stays 0 for 10000 bits, bit_cnt=10000-64.
REQ-029 While locked, invert one din bit -> one err_pulse, err_cnt=1, locked stays 1.
REQ-030 While locked, invert 4 bits within 64 valid bits -> err_cnt=4, locked falls one cycle after the 4th error, relocks after 64 further clean bits.
REQ-031 din held 0 with din_valid=1 for 1000 cycles -> never leaves HUNT, locked 0, err_pulse never asserted.
REQ-032 Clean stream with din_valid toggling 1/0 -> locks after 64 valid bits (128 cycles), no errors.
REQ-033 clr_cnt asserted on same cycle as an error in LOCKED -> err_pulse=1, err_cnt=0 next cycle; build without M_SEQ_32_CHK_BITCNT_EN -> bit_cnt reads 0 throughout.

Source files
------------

// File: rtl/m_seq_32_chk.sv
// PRBS checker for the x^32+x^22+x^2+x+1 m-sequence: hunt, self-synchronise, lock, count errors.
// Latency: locked, err_pulse and the counters are registered, one cycle after the sampling edge.
// Backpressure: none. Bits with din_valid=0 are skipped. Optional bit counter under M_SEQ_32_CHK_BITCNT_EN.
module m_seq_32_chk #(
   parameter int SYNC_LEN = 32,
   parameter int LOS_WIN  = 64,
   parameter int LOS_ERR  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        din_valid,
   input  logic        din,
   input  logic        clr_cnt,
   output logic        locked,
   output logic        err_pulse,
   output logic [31:0] err_cnt,
   output logic [31:0] bit_cnt
);

   localparam logic [1:0] ST_HUNT   = 2'd0;
   localparam logic [1:0] ST_SYNC   = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   localparam int SYNC_W = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;
   localparam int WIN_W  = (LOS_WIN  > 1) ? $clog2(LOS_WIN)  : 1;
   localparam int ERR_W  = $clog2(LOS_ERR + 1);

   logic [1:0]        r_state;
   logic [31:0]       r_sr;
   logic [4:0]        r_fill;
   logic [SYNC_W-1:0] r_sync;
   logic [WIN_W-1:0]  r_win_bit;
   logic [ERR_W-1:0]  r_win_err;
   logic              r_err_pulse;
   logic [31:0]       r_err_cnt;

   logic              w_exp;
   logic              w_err;
   logic [31:0]       w_sr_hunt;
   logic [31:0]       w_sr_run;
   logic [ERR_W-1:0]  w_win_err_nxt;
   logic              w_chk_bit;

   // Expected bit comes from the local reference only; din is loaded into it in HUNT alone,
   // so a single corrupted bit cannot propagate into further mismatches.
   assign w_exp         = r_sr[31] ^ r_sr[21] ^ r_sr[1] ^ r_sr[0];
   assign w_err         = (din != w_exp);
   assign w_sr_hunt     = {r_sr[30:0], din};
   assign w_sr_run      = {r_sr[30:0], w_exp};
   assign w_win_err_nxt = r_win_err + ERR_W'(w_err);
   assign w_chk_bit     = din_valid && (r_state != ST_HUNT);

   // Acquisition / tracking state machine, advanced only by valid bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_HUNT;
         r_sr      <= '0;
         r_fill    <= '0;
         r_sync    <= '0;
         r_win_bit <= '0;
         r_win_err <= '0;
      end else if (din_valid) begin
         case (r_state)
            ST_HUNT: begin
               r_sr <= w_sr_hunt;
               if (r_fill == 5'd31) begin
                  // An all-zero reference is the lock-up state of the generator; keep hunting.
                  r_fill <= '0;
                  if (w_sr_hunt != '0) begin
                     r_state <= ST_SYNC;
                     r_sync  <= '0;
                  end
               end else begin
                  r_fill <= r_fill + 5'd1;
               end
            end
            ST_SYNC: begin
               r_sr <= w_sr_run;
               if (w_err) begin
                  r_state <= ST_HUNT;
                  r_fill  <= '0;
               end else if (r_sync == SYNC_W'(SYNC_LEN - 1)) begin
                  r_state   <= ST_LOCKED;
                  r_win_bit <= '0;
                  r_win_err <= '0;
               end else begin
                  r_sync <= r_sync + SYNC_W'(1);
               end
            end
            ST_LOCKED: begin
               r_sr <= w_sr_run;
               if (w_win_err_nxt >= ERR_W'(LOS_ERR)) begin
                  r_state <= ST_HUNT;
                  r_fill  <= '0;
               end
               if (r_win_bit == WIN_W'(LOS_WIN - 1)) begin
                  r_win_bit <= '0;
                  r_win_err <= '0;
               end else begin
                  r_win_bit <= r_win_bit + WIN_W'(1);
                  r_win_err <= w_win_err_nxt;
               end
            end
            default: begin
               r_state <= ST_HUNT;
               r_fill  <= '0;
            end
         endcase
      end
   end

   // One-cycle error flag for every mismatch seen while synchronising or locked.
   always_ff @(posedge clk) begin
      if (reset) r_err_pulse <= 1'b0;
      else       r_err_pulse <= w_chk_bit && w_err;
   end

   // Saturating error counter; clear wins over a same-cycle increment.
   always_ff @(posedge clk) begin
      if (reset || clr_cnt) begin
         r_err_cnt <= '0;
      end else if (din_valid && (r_state == ST_LOCKED) && w_err && (r_err_cnt != 32'hFFFF_FFFF)) begin
         r_err_cnt <= r_err_cnt + 32'd1;
      end
   end

`ifdef M_SEQ_32_CHK_BITCNT_EN
   logic [31:0] r_bit_cnt;

   // Saturating count of bits checked while locked; clear wins over a same-cycle increment.
   always_ff @(posedge clk) begin
      if (reset || clr_cnt) begin
         r_bit_cnt <= '0;
      end else if (din_valid && (r_state == ST_LOCKED) && (r_bit_cnt != 32'hFFFF_FFFF)) begin
         r_bit_cnt <= r_bit_cnt + 32'd1;
      end
   end

   assign bit_cnt = r_bit_cnt;
`else
   assign bit_cnt = 32'h0;
`endif

   assign locked    = (r_state == ST_LOCKED);
   assign err_pulse = r_err_pulse;
   assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_m_seq_32_chk.sv
// Directed bench for m_seq_32_chk driven by a seeded m-sequence generator.
module tb_m_seq_32_chk;

   logic        clk = 1'b0;
   logic        reset;
   logic        din_valid;
   logic        din;
   logic        clr_cnt;
   logic        locked;
   logic        err_pulse;
   logic [31:0] err_cnt;
   logic [31:0] bit_cnt;

   int          checks = 0;
   int          errors = 0;
   int          pulses = 0;
   int          lock_seen = 0;
   int          nlk = 0;
   logic [31:0] g = 32'h789ABCDE;

`ifdef M_SEQ_32_CHK_BITCNT_EN
   localparam bit BC_EN = 1'b1;
`else
   localparam bit BC_EN = 1'b0;
`endif

   m_seq_32_chk dut (
      .clk       (clk),
      .reset     (reset),
      .din_valid (din_valid),
      .din       (din),
      .clr_cnt   (clr_cnt),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_cnt   (err_cnt),
      .bit_cnt   (bit_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] bexp(input int v);
      return BC_EN ? 32'(v) : 32'h0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock: v=1 sends the next generator bit (optionally inverted), v=0 sends junk.
   task automatic step(input logic v, input logic flip);
      logic nb;
      if (v) begin
         nb = g[31] ^ g[21] ^ g[1] ^ g[0];
         g  = {g[30:0], nb};
         din = nb ^ flip;
         if (locked) nlk++;
      end else begin
         din = 1'($urandom);
      end
      din_valid = v;
      @(posedge clk);
      #1;
      if (err_pulse) pulses++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0);
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      din_valid = 1'b0;
      clr_cnt   = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset  = 1'b0;
      pulses = 0;
      nlk    = 0;
   endtask

   initial begin
      reset = 1'b1; din_valid = 1'b0; din = 1'b0; clr_cnt = 1'b0;
      do_reset();
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_err_pulse", 32'(err_pulse), 32'd0);
      chk("rst_err_cnt", err_cnt, 32'd0);
      chk("rst_bit_cnt", bit_cnt, 32'd0);

      // Clean stream: lock exactly after 64 valid bits, then 10000 bits in total.
      run(63);
      chk("lock_at_63", 32'(locked), 32'd0);
      step(1'b1, 1'b0);
      chk("lock_at_64", 32'(locked), 32'd1);
      run(10000 - 64);
      chk("clean_err_cnt", err_cnt, 32'd0);
      chk("clean_bit_cnt", bit_cnt, bexp(9936));
      chk("clean_locked", 32'(locked), 32'd1);
      chk("clean_pulses", 32'(pulses), 32'd0);

      // Single inverted bit while locked.
      step(1'b1, 1'b1);
      chk("single_pulse", 32'(err_pulse), 32'd1);
      chk("single_err_cnt", err_cnt, 32'd1);
      chk("single_locked", 32'(locked), 32'd1);
      step(1'b1, 1'b0);
      chk("single_pulse_off", 32'(err_pulse), 32'd0);
      run(128);
      chk("single_err_hold", err_cnt, 32'd1);
      chk("single_pulse_total", 32'(pulses), 32'd1);
      chk("single_still_locked", 32'(locked), 32'd1);

      // Clear on the same cycle as an error.
      clr_cnt = 1'b1;
      step(1'b1, 1'b1);
      clr_cnt = 1'b0;
      chk("clr_pulse", 32'(err_pulse), 32'd1);
      chk("clr_err_cnt", err_cnt, 32'd0);
      chk("clr_bit_cnt", bit_cnt, 32'd0);
      run(128);
      chk("post_clr_bit_cnt", bit_cnt, bexp(128));
      chk("post_clr_err_cnt", err_cnt, 32'd0);

      // Four errors in one loss-of-sync window, starting on a window boundary.
      while ((nlk % 64) != 0) step(1'b1, 1'b0);
      step(1'b1, 1'b1); run(9);
      step(1'b1, 1'b1); run(9);
      step(1'b1, 1'b1);
      chk("los_third_locked", 32'(locked), 32'd1);
      run(9);
      step(1'b1, 1'b1);
      chk("los_fourth_pulse", 32'(err_pulse), 32'd1);
      chk("los_locked_fall", 32'(locked), 32'd0);
      chk("los_err_cnt", err_cnt, 32'd4);
      run(63);
      chk("relock_at_63", 32'(locked), 32'd0);
      chk("los_err_cnt_hold", err_cnt, 32'd4);
      step(1'b1, 1'b0);
      chk("relock_at_64", 32'(locked), 32'd1);

      // Reset while locked abandons lock and clears counters.
      do_reset();
      chk("midrst_locked", 32'(locked), 32'd0);
      chk("midrst_err_cnt", err_cnt, 32'd0);
      chk("midrst_bit_cnt", bit_cnt, 32'd0);

      // din_valid toggling: 64 valid bits spread over 128 cycles.
      for (int i = 0; i < 63; i++) begin
         step(1'b0, 1'b0);
         step(1'b1, 1'b0);
      end
      step(1'b0, 1'b0);
      chk("toggle_127", 32'(locked), 32'd0);
      step(1'b1, 1'b0);
      chk("toggle_128", 32'(locked), 32'd1);
      chk("toggle_pulses", 32'(pulses), 32'd0);

      // Error during SYNC: pulse, back to HUNT, nothing counted.
      do_reset();
      run(40);
      step(1'b1, 1'b1);
      chk("sync_err_pulse", 32'(err_pulse), 32'd1);
      chk("sync_err_locked", 32'(locked), 32'd0);
      chk("sync_err_cnt", err_cnt, 32'd0);
      run(63);
      chk("sync_relock_63", 32'(locked), 32'd0);
      step(1'b1, 1'b0);
      chk("sync_relock_64", 32'(locked), 32'd1);

      // All-zero input never leaves HUNT.
      do_reset();
      lock_seen = 0;
      for (int i = 0; i < 1024; i++) begin
         din = 1'b0;
         din_valid = 1'b1;
         @(posedge clk); #1;
         if (err_pulse) pulses++;
         if (locked) lock_seen++;
      end
      chk("zero_pulses", 32'(pulses), 32'd0);
      chk("zero_lock_seen", 32'(lock_seen), 32'd0);
      chk("zero_bit_cnt", bit_cnt, 32'd0);
      run(63);
      chk("zero_then_63", 32'(locked), 32'd0);
      step(1'b1, 1'b0);
      chk("zero_then_64", 32'(locked), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
